// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus state encoding and ACK/NACK line levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus one history flop, with single-cycle edge strobes.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0],[1] synchronizer stages, [2] history of the synced level
  logic [2:0] sh_q, sh_d;

  // shift the raw line through the synchronizer and history stages
  always_comb begin
    sh_d = {sh_q[1:0], din};
  end

  // reset to the idle-high bus level so no edge is reported out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= 3'b111;
    else     sh_q <= sh_d;
  end

  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];
  assign fall  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: START/STOP detection, 7-bit address match, byte rx/tx handshake.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] OWN_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_sync u_scl (.clk(clk), .rst(rst), .din(i2c_scl),
                       .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda (.clk(clk), .rst(rst), .din(i2c_sda),
                       .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  assign start = scl_lvl & sda_fall;
  assign stop  = scl_lvl & sda_rise;

  i2c_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // bits shifted in, or bits driven out
  logic [7:0]  sr_q, sr_d;          // receive shift register
  logic [7:0]  tx_sr_q, tx_sr_d;    // transmit byte, MSB at [7]
  logic        rw_q, rw_d;
  logic        flag_q, flag_d;      // ACK slot: low driven / master ACK seen
  logic        sda_low_q, sda_low_d;
  logic        rx_pend_q, rx_pend_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_load;

  // state register and all datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      tx_sr_q    <= '0;
      rw_q       <= 1'b0;
      flag_q     <= 1'b0;
      sda_low_q  <= 1'b0;
      rx_pend_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      tx_sr_q    <= tx_sr_d;
      rw_q       <= rw_d;
      flag_q     <= flag_d;
      sda_low_q  <= sda_low_d;
      rx_pend_q  <= rx_pend_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // next-state: bus conditions first, then per-state SCL-edge handling
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    tx_sr_d    = tx_sr_q;
    rw_d       = rw_q;
    flag_d     = flag_q;
    sda_low_d  = sda_low_q;
    rx_pend_d  = 1'b0;
    // completed byte is published one clk after its last bit
    rx_valid_d = rx_pend_q;
    rx_data_d  = rx_pend_q ? sr_q : rx_data_q;
    tx_load    = 1'b0;

    if (start) begin
      state_d   = ADDR;
      cnt_d     = '0;
      flag_d    = 1'b0;
      sda_low_d = 1'b0;
    end else if (stop) begin
      state_d   = IDLE;
      cnt_d     = '0;
      flag_d    = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sr_d  = {sr_q[6:0], sda_lvl};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d  = '0;
            rw_d   = sda_lvl;
            flag_d = 1'b0;
            state_d = (sr_q[6:0] == OWN_ADDR) ? ADDR_ACK : WAIT_STOP;
          end
        end
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          if (!flag_q) begin
            sda_low_d = 1'b1;
            flag_d    = 1'b1;
          end else begin
            sda_low_d = 1'b0;
            flag_d    = 1'b0;
            cnt_d     = '0;
            if (state_q == ADDR_ACK && rw_q) tx_load = 1'b1;
            else                             state_d = RX_BYTE;
          end
        end
        RX_BYTE: if (scl_rise) begin
          sr_d  = {sr_q[6:0], sda_lvl};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d     = '0;
            rx_pend_d = 1'b1;
            flag_d    = 1'b0;
            state_d   = RX_ACK;
          end
        end
        TX_BYTE: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_low_d = 1'b0;
            flag_d    = 1'b0;
            state_d   = TX_ACK;
          end else begin
            sda_low_d = ~tx_sr_q[6];
            tx_sr_d   = {tx_sr_q[6:0], 1'b0};
            cnt_d     = cnt_q + 4'd1;
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) flag_d  = 1'b1;
            else                    state_d = WAIT_STOP;
          end else if (scl_fall && flag_q) begin
            tx_load = 1'b1;
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_d = IDLE;
      endcase

      // fetch the next byte and put its MSB on the line right away
      if (tx_load) begin
        tx_sr_d   = tx_data;
        sda_low_d = ~tx_data[7];
        cnt_d     = 4'd1;
        flag_d    = 1'b0;
        state_d   = TX_BYTE;
      end
    end
  end

  // outputs: busy from state, open-drain SDA from the drive flop
  always_comb begin
    busy = 1'b0;
    case (state_q)
      ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
  assign tx_req   = tx_load;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

Responder (target) end of the team's single-master I2C bus, running entirely in the system clock domain. It oversamples SCL and SDA, detects START and STOP conditions, and matches a 7-bit address. On a match it either accepts write bytes (ACKing each one) or serves read bytes from a local register interface. It sits on the far side of the bus from the I2C master controller and gives on-chip logic a byte-level rx/tx handshake.

## Interface
- `OWN_ADDR`, default 7'h50: 7-bit bus address this block answers to.
- `clk`  in  1: system clock. SCL high and low phases must each be ≥ 8 `clk` periods.
- `rst`  in  1: reset, asynchronous, active-high.
- `i2c_scl`  in  1: bus clock. Input only; no clock stretching.
- `i2c_sda`  inout  1: bus data, open-drain. The block drives only 0, otherwise `z`.
- `tx_data`  in  8: byte returned on the next read byte; sampled at `tx_req`.
- `tx_req`  out  1: one-`clk` pulse in the cycle `tx_data` is latched.
- `rx_data`  out  8: last byte written by the master; held until the next byte completes.
- `rx_valid`  out  1: one-`clk` pulse when `rx_data` updates.
- `busy`  out  1: high from an address-matched ACK until STOP or NACK-terminated idle.

## Operation
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer plus one history flop.
  - All decisions use the synced values.
  - `scl_rise`/`scl_fall` are single-cycle edge strobes.
- Bus conditions:
  - START = SCL high and SDA falling.
  - STOP = SCL high and SDA rising.
  - START in any state (repeated START included) → ADDR with the bit count cleared; this has priority over all other transitions.
  - STOP in any state → IDLE and release SDA.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift SDA MSB-first on each `scl_rise`. After the 8th bit, compare bits[7:1] with `OWN_ADDR`.
    - Match → ADDR_ACK.
    - Mismatch → WAIT_STOP. No ACK is driven and no outputs pulse.
  - ADDR_ACK:
    - On the next `scl_fall`, pull SDA low.
    - On the following `scl_fall`, release SDA.
    - R/W=0 → RX_BYTE.
    - R/W=1 → pulse `tx_req`, latch `tx_data`, drive its bit 7 in the same cycle, then go to TX_BYTE.
  - RX_BYTE: shift 8 bits on `scl_rise`. After the 8th, update `rx_data`, pulse `rx_valid` in the next `clk`, then go to RX_ACK.
  - RX_ACK: ACK is driven exactly as in ADDR_ACK, then return to RX_BYTE. Every written byte is ACKed; there is no overflow NACK.
  - TX_BYTE:
    - Drive each bit (0 = pull low, 1 = release) on `scl_fall`.
    - After the 8th bit's `scl_fall`, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on `scl_rise`.
    - 0 (master ACK) → on `scl_fall`, pulse `tx_req`, latch a new byte, drive bit 7, return to TX_BYTE.
    - 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- `busy` is high in ADDR_ACK through TX_ACK and low in IDLE, ADDR and WAIT_STOP.

## Timing
- Reset values:
  - state IDLE, SDA released, bit counter 0.
  - `rx_data`=8'h00; `rx_valid`, `tx_req`, `busy` = 0.
- Reset asserted mid-transfer releases SDA in the same instant (asynchronous).
- Latency from a physical SCL edge to its strobe: 3 `clk`. SDA changes 3–4 `clk` after SCL falls, well inside the required low phase.
- `rx_valid` asserts 4 `clk` after the 8th rising SCL of a data byte.
- A START or STOP seen in the same cycle as an `scl_rise`/`scl_fall` strobe wins.
- `tx_data` must be stable in the `tx_req` cycle. There is no backpressure.

## Structure
- Package `i2c_pkg`: state enum (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP) and constants `I2C_ACK`=1'b0, `I2C_NACK`=1'b1. Shared with the master.
- Sub-module `i2c_line_sync`: 2-flop synchronizer plus edge detect, outputs `level`/`rise`/`fall`. Instantiated once for SCL and once for SDA.

## Test plan
- Write 0x50, data 8'hA5:
  - Address and data are both ACKed (SDA low at the 9th SCL high).
  - One `rx_valid` pulse with `rx_data`=8'hA5.
  - `busy` falls after STOP.
- Read 0x50 with `tx_data`=8'h3C:
  - Master receives 8'h3C.
  - `tx_req` pulses once before the first data bit.
  - Master ACK then STOP → IDLE.
- Address 0x51:
  - SDA stays released at the 9th clock; master sees NACK and issues STOP.
  - No `rx_valid`, `tx_req` or `busy`.
- Three-byte write 0x11, 0x22, 0x33: three `rx_valid` pulses with matching `rx_data`.
- Repeated START after 4 bits of a write byte:
  - Returns to ADDR; no `rx_valid`.
  - The following read of 0x50 returns `tx_data`.
- Assert `rst` while the block drives ACK low: SDA goes to `z` immediately and all outputs return to reset values.
